// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED sequencer: pattern mode and FSM state
// encodings, the reset-time step period, and the pattern helper functions.
// ---------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SHIFT = 2'd1,
        MODE_GRAY  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam int DEFAULT_PERIOD = 13500000;

    // Next 3-bit reflected Gray code: decode to binary, increment, re-encode.
    function automatic logic [2:0] gray_next(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        b    = b + 3'd1;
        return b ^ (b >> 1);
    endfunction

    // Pattern value a mode starts from when a sequence (re)starts.
    function automatic logic [2:0] mode_init(input mode_e m);
        return (m == MODE_SHIFT) ? 3'b001 : 3'b000;
    endfunction

    function automatic logic [2:0] pattern_advance(input logic [2:0] p, input mode_e m);
        logic [2:0] n;
        case (m)
            MODE_COUNT: n = p + 3'd1;
            MODE_SHIFT: n = {p[1:0], p[2]};
            MODE_GRAY:  n = gray_next(p);
            default:    n = ~p;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// ---------------------------------------------------------------------------
// led_tick_gen
// Period counter. While enabled it counts 0..period and raises tick in the
// cycle the count sits at period; the count wraps to 0 on that edge.
//   clk, rst : clock, asynchronous active-high reset
//   enable   : count this cycle
//   clear    : force the count to 0 on the next edge (wins over enable)
//   period   : terminal count (step interval minus one)
//   tick     : combinational, enable && count reached period
// ---------------------------------------------------------------------------
module led_tick_gen #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // >= rather than == so a period shortened during PAUSE below the held
    // count wraps on the next step instead of running through 2^CNT_W.
    assign tick = enable && (cnt_q >= period);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
// Three-LED pattern sequencer with IDLE/RUN/PAUSE control.
//   clk, rst   : clock, asynchronous active-high reset
//   cfg_valid  : config offer; cfg_ready: accept. A transfer is valid&ready,
//                and ready is high only in IDLE and PAUSE, so the period and
//                mode never change under a running sequence.
//   cfg_period : cycles per step minus one; cfg_mode: COUNT/SHIFT/GRAY/BLINK
//   start/stop : level requests sampled every edge; stop wins over start
//   busy       : high in RUN and PAUSE
//   step_pulse : high for the cycle in which led shows a freshly advanced value
//   led        : active-low drive of the pattern (registered)
//   state_dbg  : current FSM state, for observation only
// ---------------------------------------------------------------------------
module led_seq_ctrl import led_pkg::*; #(
    parameter int CNT_W          = 24,
    parameter int DEFAULT_PERIOD = led_pkg::DEFAULT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [1:0]       cfg_mode,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             step_pulse,
    output logic [2:0]       led,
    output logic [1:0]       state_dbg
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [2:0]       pattern_q, pattern_d;
    logic [2:0]       led_q;
    logic             step_q, step_d;
    logic             busy_q;
    logic             ready_q;
    logic             xfer;
    logic             tick_en;
    logic             tick_clr;
    logic             tick;

    led_tick_gen #(.CNT_W(CNT_W)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (tick_en),
        .clear  (tick_clr),
        .period (period_q),
        .tick   (tick)
    );

    assign xfer = cfg_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        mode_d    = xfer ? mode_e'(cfg_mode) : mode_q;
        period_d  = xfer ? cfg_period : period_q;
        pattern_d = pattern_q;
        step_d    = 1'b0;
        tick_en   = 1'b0;
        tick_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tick_clr  = 1'b1;
                pattern_d = 3'b000;
                if (start && !stop) begin
                    state_d   = ST_RUN;
                    // Uses the mode being written on this same edge, if any.
                    pattern_d = mode_init(mode_d);
                end
            end
            ST_RUN: begin
                if (stop) begin
                    // Pausing on the terminal count suppresses that step.
                    state_d = ST_PAUSE;
                end else begin
                    tick_en = 1'b1;
                    if (tick) begin
                        pattern_d = pattern_advance(pattern_q, mode_q);
                        step_d    = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    tick_clr  = 1'b1;
                    pattern_d = 3'b000;
                end else begin
                    // A pattern from the old mode is meaningless in the new one.
                    if (xfer && (mode_d != mode_q)) begin
                        pattern_d = mode_init(mode_d);
                        tick_clr  = 1'b1;
                    end
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                tick_clr  = 1'b1;
                pattern_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_COUNT;
            period_q  <= CNT_W'(DEFAULT_PERIOD);
            pattern_q <= 3'b000;
            led_q     <= 3'b111;
            step_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            period_q  <= period_d;
            pattern_q <= pattern_d;
            led_q     <= ~pattern_d;
            step_q    <= step_d;
            busy_q    <= (state_d != ST_IDLE);
            ready_q   <= (state_d != ST_RUN);
        end
    end

    assign cfg_ready  = ready_q;
    assign busy       = busy_q;
    assign step_pulse = step_q;
    assign led        = led_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
module tb_led_seq_ctrl;
  import led_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_period;
  logic [1:0]  cfg_mode;
  logic        start;
  logic        stop;
  logic        busy;
  logic        step_pulse;
  logic [2:0]  led;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;

  led_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_mode   (cfg_mode),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .step_pulse (step_pulse),
    .led        (led),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: every step_pulse must show the next queued led value
  always @(negedge clk) begin
    if (!rst && step_pulse) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL step_led: unexpected step, led=%b, expected no step", led);
      end else begin
        mon_exp = exp_q.pop_front();
        if (led !== mon_exp) begin
          failures++;
          $display("FAIL step_led: led=%b expected=%b", led, mon_exp);
        end
      end
    end
  end

  // driver helpers
  task automatic wait_step(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!step_pulse && cycles <= budget);
  endtask

  task automatic drive_cfg(input logic [23:0] p, input logic [1:0] m);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_mode   = m;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_period = '0; cfg_mode = '0;
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (led !== 3'b111 || busy !== 1'b0 || cfg_ready !== 1'b1 || step_pulse !== 1'b0 || state_dbg !== 2'(ST_IDLE)) begin
      failures++;
      $display("FAIL reset_state: led=%b busy=%b ready=%b step=%b st=%0d expected 111/0/1/0/0",
               led, busy, cfg_ready, step_pulse, state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_count();
    int c;
    drive_cfg(24'd3, 2'd0);
    start = 1'b1;
    for (int k = 1; k <= 8; k++) exp_q.push_back(~3'(k));
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    checks++;
    if (led !== 3'b111 || busy !== 1'b1 || cfg_ready !== 1'b0 || step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL count_start: led=%b busy=%b ready=%b step=%b expected 111/1/0/0",
               led, busy, cfg_ready, step_pulse);
    end
    for (int k = 0; k < 8; k++) begin
      wait_step(8, c);
      checks++;
      if (c !== 4) begin
        failures++;
        $display("FAIL count_interval: step %0d after %0d cycles expected 4", k, c);
      end
    end
    stop = 1'b1;
    repeat (2) @(negedge clk);
    stop = 1'b0;
    checks++;
    if (state_dbg !== 2'(ST_IDLE) || led !== 3'b111 || busy !== 1'b0) begin
      failures++;
      $display("FAIL count_to_idle: st=%0d led=%b busy=%b expected 0/111/0", state_dbg, led, busy);
    end
  endtask

  task automatic test_shift();
    drive_cfg(24'd0, 2'd1);
    start = 1'b1;
    exp_q.push_back(~3'b010); exp_q.push_back(~3'b100);
    exp_q.push_back(~3'b001); exp_q.push_back(~3'b010);
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    checks++;
    if (led !== 3'b110 || step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL shift_init: led=%b step=%b expected 110/0", led, step_pulse);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (step_pulse !== 1'b1) begin
        failures++;
        $display("FAIL shift_pulse: cycle %0d step=%b expected 1", k, step_pulse);
      end
    end
    stop = 1'b1;
    repeat (2) @(negedge clk);
    stop = 1'b0;
  endtask

  // GRAY run paused exactly on the terminal count, then resumed
  task automatic test_pause_gray();
    int c;
    drive_cfg(24'd2, 2'd2);
    start = 1'b1;
    exp_q.push_back(~3'b001);
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    wait_step(8, c);
    checks++;
    if (c !== 3) begin
      failures++;
      $display("FAIL gray_interval: %0d cycles expected 3", c);
    end
    repeat (2) @(negedge clk);   // counter now equals period
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (state_dbg !== 2'(ST_PAUSE) || led !== 3'b110 || busy !== 1'b1 || cfg_ready !== 1'b1 || step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL pause_at_period: st=%0d led=%b busy=%b ready=%b step=%b expected 2/110/1/1/0",
               state_dbg, led, busy, cfg_ready, step_pulse);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (led !== 3'b110) begin
      failures++;
      $display("FAIL pause_hold: led=%b expected 110", led);
    end
    exp_q.push_back(~3'b011);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (state_dbg !== 2'(ST_RUN) || step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL resume: st=%0d step=%b expected 1/0", state_dbg, step_pulse);
    end
    wait_step(8, c);
    checks++;
    if (c !== 1) begin
      failures++;
      $display("FAIL resume_step: %0d cycles expected 1", c);
    end
  endtask

  // config offered while running is held off until PAUSE
  task automatic test_cfg_in_run();
    int c;
    exp_q.push_back(~3'b010);
    drive_cfg(24'd0, 2'd1);
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_in_run: ready=%b expected 0", cfg_ready);
    end
    wait_step(8, c);             // one of the three cycles already elapsed
    checks++;
    if (c !== 2) begin
      failures++;
      $display("FAIL run_cfg_ignored: %0d cycles expected 2", c);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (led !== 3'b101 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL stop_no_xfer: led=%b ready=%b expected 101/1", led, cfg_ready);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if (led !== 3'b110) begin
      failures++;
      $display("FAIL pause_xfer: led=%b expected 110", led);
    end
    exp_q.push_back(~3'b010); exp_q.push_back(~3'b100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_step(8, c);
      checks++;
      if (c !== 1) begin
        failures++;
        $display("FAIL new_period: step %0d after %0d cycles expected 1", k, c);
      end
    end
  endtask

  task automatic test_start_stop_together();
    stop = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (state_dbg !== 2'(ST_IDLE) || led !== 3'b111 || busy !== 1'b0) begin
      failures++;
      $display("FAIL both_in_pause: st=%0d led=%b busy=%b expected 0/111/0", state_dbg, led, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL both_in_idle: busy=%b ready=%b expected 0/1", busy, cfg_ready);
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int c;
    drive_cfg(24'd1, 2'd3);
    start = 1'b1;
    exp_q.push_back(3'b000);
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    wait_step(8, c);
    checks++;
    if (c !== 2) begin
      failures++;
      $display("FAIL blink_interval: %0d cycles expected 2", c);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (led !== 3'b111 || busy !== 1'b0 || cfg_ready !== 1'b1 || step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: led=%b busy=%b ready=%b step=%b expected 111/0/1/0",
               led, busy, cfg_ready, step_pulse);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || led !== 3'b111) begin
      failures++;
      $display("FAIL restart_default: busy=%b led=%b expected 1/111", busy, led);
    end
    wait_step(40, c);
    checks++;
    if (c !== 41) begin
      failures++;
      $display("FAIL default_period: step after %0d cycles expected none within 40", c);
    end
    stop = 1'b1;
    repeat (2) @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_shift();
    test_pause_gray();
    test_cfg_in_run();
    test_start_stop_together();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d steps outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter: CNT_W, default 24, width of the period counter and cfg_period.
REQ-002 Parameter: DEFAULT_PERIOD, default 13500000, period loaded at reset.
REQ-003 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: cfg_valid  in  1  config offer.
REQ-006 Port: cfg_ready  out  1  config accept; cfg_valid&cfg_ready is a transfer.
REQ-007 Port: cfg_period  in  CNT_W  cycles per step minus one.
REQ-008 Port: cfg_mode  in  2  pattern: 0 COUNT, 1 SHIFT, 2 GRAY, 3 BLINK.
REQ-009 Port: start  in  1  run/resume request, level sampled each cycle.
REQ-010 Port: stop  in  1  pause/halt request, level sampled each cycle.
REQ-011 Port: busy  out  1  high in RUN and PAUSE.
REQ-012 Port: step_pulse  out  1  one-cycle pulse coincident with each pattern advance.
REQ-013 Port: led  out  3  active-low LED drive, led = ~pattern, registered.

Function
REQ-014 FSM states IDLE, RUN, PAUSE. IDLE+start -> RUN; RUN+stop -> PAUSE; PAUSE+start -> RUN; PAUSE+stop -> IDLE; all other cases hold.
REQ-015 start and stop asserted together: stop wins.
REQ-016 cfg_ready = 1 in IDLE and PAUSE, 0 in RUN; a transfer updates period and mode registers on that edge.
REQ-017 Transfer and IDLE->RUN on the same edge: new period/mode take effect, pattern loads the new mode's initial value.
REQ-018 Transfer in PAUSE: period/mode update, pattern and counter retained; mode change re-initialises pattern to new mode's initial value and clears the counter.
REQ-019 IDLE->RUN: counter cleared, pattern = mode initial (COUNT 000, SHIFT 001, GRAY 000, BLINK 000).
REQ-020 PAUSE->RUN: counter and pattern resume unchanged.
REQ-021 Entering IDLE: counter cleared, pattern = 000 (led = 111).
REQ-022 In RUN: counter < period -> counter+1; counter == period -> counter = 0, pattern advances, step_pulse = 1 for that cycle.
REQ-023 Step interval is period+1 cycles; period 0 gives a step every RUN cycle.
REQ-024 Counter holds in PAUSE; step_pulse = 0 outside RUN.
REQ-025 Advance rules: COUNT +1 mod 8 (111->000); SHIFT rotate left (100->001); GRAY 000,001,011,010,110,111,101,100,000; BLINK bitwise invert.
REQ-026 RUN->PAUSE on an edge where counter == period: stop wins, no advance, no step_pulse.

Reset
REQ-027 rst asserted: state IDLE, counter 0, pattern 000, led 111, step_pulse 0, busy 0, cfg_ready 1, period = DEFAULT_PERIOD, mode COUNT; effective immediately, independent of clk.
REQ-028 Reset mid-RUN aborts the sequence; first edge after release behaves as IDLE.

Structure
REQ-029 Shared package led_pkg holds the mode enum, FSM state enum, DEFAULT_PERIOD and Gray-next function.
REQ-030 Period counter is the sub-module led_tick_gen (enable, clear, period in; tick out); the FSM and pattern logic live in led_seq_ctrl.

Verification
REQ-031 Reset, then period=3 mode=COUNT, start one cycle -> led 111,110,101,... changing every 4 cycles, step_pulse with each change, 7->0 wrap after 8 steps.
REQ-032 Mode SHIFT, period=0, start -> pattern 001,010,100,001 on consecutive cycles, step_pulse continuously high.
REQ-033 RUN in GRAY, stop at counter==period -> no advance, busy=1, cfg_ready=1; start -> resumes, next step after exactly one cycle.
REQ-034 cfg_valid during RUN -> cfg_ready=0, no config change; same offer accepted the first cycle after stop.
REQ-035 start and stop together in PAUSE -> IDLE, led=111, busy=0.
REQ-036 rst pulsed mid-RUN between clock edges -> led=111 and busy=0 before next edge; period back to 13500000.
